// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer.
//   MAX_LOG2N        : largest supported transform exponent
//   ADDR_W           : sample address width
//   fft_addr_t       : sample address type
//   fft_ctrl_state_t : sequencer states
package fft_pkg;

  localparam int unsigned MAX_LOG2N = 12;
  localparam int unsigned ADDR_W    = MAX_LOG2N;

  typedef logic [ADDR_W-1:0] fft_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator for an in-place radix-2 DIT FFT.
//   b_i       : butterfly index within the stage
//   s_i       : stage index
//   l_i       : transform exponent L
//   addr_a_o  : top sample address
//   addr_b_o  : bottom sample address (addr_a_o + span)
//   tw_idx_o  : twiddle ROM index
//   last_bf_o : b_i is the last butterfly of its stage
module fft_bf_addr_gen #(
  parameter  int unsigned MAX_LOG2N = fft_pkg::MAX_LOG2N,
  localparam int unsigned ADDR_W    = MAX_LOG2N,
  localparam int unsigned BCNT_W    = MAX_LOG2N - 1
) (
  input  logic [BCNT_W-1:0] b_i,
  input  logic [3:0]        s_i,
  input  logic [3:0]        l_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [ADDR_W-2:0] tw_idx_o,
  output logic              last_bf_o
);
  import fft_pkg::*;

  logic [ADDR_W-1:0] b_ext;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] tw_full;
  logic [3:0]        tw_sh;

  // Insert a zero bit at position s into b to get the top address of the pair.
  always_comb begin
    b_ext     = ADDR_W'(b_i);
    span      = ADDR_W'(1) << s_i;
    pos       = b_ext & (span - ADDR_W'(1));
    grp       = b_ext >> s_i;
    addr_a_o  = (grp << (s_i + 4'd1)) | pos;
    addr_b_o  = addr_a_o | span;
    tw_sh     = l_i - 4'd1 - s_i;
    tw_full   = pos << tw_sh;
    tw_idx_o  = tw_full[ADDR_W-2:0];
    last_bf_o = (b_ext == ((ADDR_W'(1) << (l_i - 4'd1)) - ADDR_W'(1)));
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT engine.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a transform (sampled in IDLE only)
//   log2n      : transform exponent L, latched on start
//   busy       : transform in progress (RUN, DRAIN, FIN)
//   done, err  : end-of-transform pulse; err flags a rejected L
//   bf_valid/bf_ready : butterfly command handshake
//   addr_a, addr_b, tw_idx, stage, last_bf : butterfly command payload
module fft_stage_ctrl #(
  parameter  int unsigned MAX_LOG2N = fft_pkg::MAX_LOG2N,
  parameter  int unsigned BF_LAT    = 4,
  localparam int unsigned ADDR_W    = MAX_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        log2n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-2:0] tw_idx,
  output logic [3:0]        stage,
  output logic              last_bf
);
  import fft_pkg::*;

  localparam int unsigned BCNT_W = MAX_LOG2N - 1;
  localparam int unsigned DR_W   = $clog2(BF_LAT + 1);

  fft_ctrl_state_t   state_q;
  logic [BCNT_W-1:0] b_q, b_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        l_q, l_d;
  logic [DR_W-1:0]   drain_q;
  logic              busy_q, done_q, err_q, bf_valid_q, last_bf_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [ADDR_W-2:0] tw_idx_q;
  logic [3:0]        stage_q;

  logic [ADDR_W-1:0] gen_a_c, gen_b_c;
  logic [ADDR_W-2:0] gen_tw_c;
  logic              gen_last_c;
  logic              xfer_c, len_ok_c, last_stage_c, drain_end_c;

  assign xfer_c       = bf_valid_q && bf_ready;
  assign len_ok_c     = (log2n != 4'd0) && (32'(log2n) <= MAX_LOG2N);
  assign last_stage_c = (s_q == (l_q - 4'd1));
  assign drain_end_c  = (drain_q == DR_W'(1));

  // Next butterfly/stage/length; the registered command is generated from these.
  always_comb begin
    b_d = b_q;
    s_d = s_q;
    l_d = l_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          l_d = log2n;
          b_d = '0;
          s_d = '0;
        end
      end
      RUN: begin
        if (xfer_c) b_d = last_bf_q ? '0 : b_q + BCNT_W'(1);
      end
      DRAIN: begin
        if (drain_end_c && !last_stage_c) s_d = s_q + 4'd1;
      end
      default: ;
    endcase
  end

  fft_bf_addr_gen #(
    .MAX_LOG2N(MAX_LOG2N)
  ) u_addr_gen (
    .b_i      (b_d),
    .s_i      (s_d),
    .l_i      (l_d),
    .addr_a_o (gen_a_c),
    .addr_b_o (gen_b_c),
    .tw_idx_o (gen_tw_c),
    .last_bf_o(gen_last_c)
  );

  // Sequencer FSM with registered command and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      s_q        <= '0;
      l_q        <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bf_valid_q <= 1'b0;
      last_bf_q  <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
      stage_q    <= '0;
    end else begin
      b_q      <= b_d;
      s_q      <= s_d;
      l_q      <= l_d;
      addr_a_q <= gen_a_c;
      addr_b_q <= gen_b_c;
      tw_idx_q <= gen_tw_c;
      stage_q  <= s_d;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len_ok_c) begin
              state_q    <= RUN;
              bf_valid_q <= 1'b1;
              last_bf_q  <= gen_last_c;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer_c && last_bf_q) begin
            state_q    <= DRAIN;
            bf_valid_q <= 1'b0;
            last_bf_q  <= 1'b0;
            drain_q    <= DR_W'(BF_LAT);
          end else begin
            last_bf_q <= gen_last_c;
          end
        end
        DRAIN: begin
          drain_q <= drain_q - DR_W'(1);
          // Counter sits at 1 in the final drain cycle, giving exactly BF_LAT cycles.
          if (drain_end_c) begin
            if (last_stage_c) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RUN;
              bf_valid_q <= 1'b1;
              last_bf_q  <= gen_last_c;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign bf_valid = bf_valid_q;
  assign last_bf  = last_bf_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_idx_q;
  assign stage    = stage_q;

endmodule
